// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: states, opcodes, writeback selects.
// CTRL_ILLEGAL_TRAP_EN adds the TRAP state for unrecognised opcodes.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'b000,
        ST_FETCH   = 3'b001,
        ST_DECODE  = 3'b010,
        ST_EXECUTE = 3'b011,
        ST_MEM     = 3'b100,
        ST_WB      = 3'b101
`ifdef CTRL_ILLEGAL_TRAP_EN
        , ST_TRAP  = 3'b110
`endif
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    function automatic logic is_legal(input logic [6:0] op);
        return op inside {OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL};
    endfunction

endpackage

// File: rtl/temporizador_mem.sv
// Memory-wait timeout: counts consecutive ack-less cycles, fires on the 2^TIMEOUT_W-th.
module temporizador_mem #(
    parameter int TIMEOUT_W = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    logic [TIMEOUT_W-1:0] cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Fires in the cycle that would be the 2^TIMEOUT_W-th miss, so an ack in that cycle wins.
    assign expired = inc && (cnt == '1);

endmodule

// File: rtl/control_multiciclo.sv
// Multicycle CPU control FSM with memory-wait timeout and sticky error.
// CTRL_ILLEGAL_TRAP_EN: unrecognised opcodes trap instead of executing as NOP.
//
// state   | meaning
// IDLE    | waiting for run_i (ignored once err_o is set)
// FETCH   | instruction read, ir_we_o on ack
// DECODE  | latch opcode, dispatch
// EXECUTE | ALU op; branches update pc here
// MEM     | data load/store, stores update pc on ack
// WB      | register writeback and pc update
// TRAP    | illegal opcode, held until reset (macro builds only)
module control_multiciclo
    import ctrl_pkg::*;
#(
    parameter int TIMEOUT_W = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       run_i,
    input  logic [6:0] opcode_i,
    input  logic       branch_taken_i,
    input  logic       mem_ack_i,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       ir_we_o,
    output logic       pc_we_o,
    output logic       pc_src_o,
    output logic       regwrite_o,
    output logic       alusrc_o,
    output logic       busy_o,
    output logic       err_o,
    output logic [1:0] wbsel_o,
    output logic [2:0] state_o
);

    state_t     state, state_next;
    logic [6:0] op_q;
    logic       err_q, err_set;
    logic       tmr_clr, tmr_inc, tmr_expired;
    state_t     end_choice;

    temporizador_mem #(.TIMEOUT_W(TIMEOUT_W)) u_tmr (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr     (tmr_clr),
        .inc     (tmr_inc),
        .expired (tmr_expired)
    );

    assign end_choice = run_i ? ST_FETCH : ST_IDLE;
    assign tmr_inc    = ((state == ST_FETCH) || (state == ST_MEM)) && !mem_ack_i;
    assign tmr_clr    = (state_next != state) &&
                        ((state_next == ST_FETCH) || (state_next == ST_MEM));

    always_comb begin
        state_next = state;
        err_set    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run_i && !err_q) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem_ack_i) begin
                    state_next = ST_DECODE;
                end else if (tmr_expired) begin
                    state_next = ST_IDLE;
                    err_set    = 1'b1;
                end
            end
            ST_DECODE: begin
                if (is_legal(opcode_i)) begin
                    state_next = ST_EXECUTE;
                end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    state_next = ST_TRAP;
                    err_set    = 1'b1;
`else
                    state_next = end_choice;
`endif
                end
            end
            ST_EXECUTE: begin
                if (op_q == OP_BRANCH)
                    state_next = end_choice;
                else if ((op_q == OP_LOAD) || (op_q == OP_STORE))
                    state_next = ST_MEM;
                else
                    state_next = ST_WB;
            end
            ST_MEM: begin
                if (mem_ack_i) begin
                    state_next = (op_q == OP_LOAD) ? ST_WB : end_choice;
                end else if (tmr_expired) begin
                    state_next = ST_IDLE;
                    err_set    = 1'b1;
                end
            end
            ST_WB: state_next = end_choice;
`ifdef CTRL_ILLEGAL_TRAP_EN
            ST_TRAP: state_next = ST_TRAP;
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ST_IDLE;
            op_q  <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_DECODE) op_q <= opcode_i;
            if (err_set) err_q <= 1'b1;
        end
    end

    always_comb begin
        mem_req_o  = 1'b0;
        mem_we_o   = 1'b0;
        ir_we_o    = 1'b0;
        pc_we_o    = 1'b0;
        pc_src_o   = 1'b0;
        regwrite_o = 1'b0;
        alusrc_o   = 1'b0;
        wbsel_o    = WB_ALU;
        busy_o     = (state != ST_IDLE);
        case (state)
            ST_FETCH: begin
                mem_req_o = 1'b1;
                ir_we_o   = mem_ack_i;
            end
            ST_DECODE: begin
`ifndef CTRL_ILLEGAL_TRAP_EN
                // Unknown opcode retires here as a NOP: step pc by 4.
                pc_we_o = !is_legal(opcode_i);
`endif
            end
            ST_EXECUTE: begin
                alusrc_o = (op_q == OP_IALU) || (op_q == OP_LOAD) || (op_q == OP_STORE);
                if (op_q == OP_BRANCH) begin
                    pc_we_o  = 1'b1;
                    pc_src_o = branch_taken_i;
                end
            end
            ST_MEM: begin
                mem_req_o = 1'b1;
                mem_we_o  = (op_q == OP_STORE);
                pc_we_o   = (op_q == OP_STORE) && mem_ack_i;
            end
            ST_WB: begin
                regwrite_o = 1'b1;
                pc_we_o    = 1'b1;
                pc_src_o   = (op_q == OP_JAL);
                if (op_q == OP_LOAD)
                    wbsel_o = WB_MEM;
                else if (op_q == OP_JAL)
                    wbsel_o = WB_PC4;
                else
                    wbsel_o = WB_ALU;
            end
            default: ;
        endcase
    end

    assign err_o   = err_q;
    assign state_o = state;

endmodule

// File: tb/tb_control_multiciclo.sv
// Directed bench for control_multiciclo; follows CTRL_ILLEGAL_TRAP_EN for the illegal-opcode case.
module tb_control_multiciclo;
    import ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n, run, taken, ack;
    logic [6:0] opcode;
    logic       mem_req, mem_we, ir_we, pc_we, pc_src, regwrite, alusrc, busy, err;
    logic [1:0] wbsel;
    logic [2:0] state;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    control_multiciclo #(.TIMEOUT_W(4)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .run_i          (run),
        .opcode_i       (opcode),
        .branch_taken_i (taken),
        .mem_ack_i      (ack),
        .mem_req_o      (mem_req),
        .mem_we_o       (mem_we),
        .ir_we_o        (ir_we),
        .pc_we_o        (pc_we),
        .pc_src_o       (pc_src),
        .regwrite_o     (regwrite),
        .alusrc_o       (alusrc),
        .busy_o         (busy),
        .err_o          (err),
        .wbsel_o        (wbsel),
        .state_o        (state)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; run = 1'b0; opcode = '0; ack = 1'b0; taken = 1'b0;
        #3;
        chk("rst_state", 8'(state), 8'(ST_IDLE));
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_err", 8'(err), 8'd0);
        chk("rst_req", 8'(mem_req), 8'd0);
        #9 rst_n = 1'b1;

        // R-type, immediate acks
        run = 1'b1; opcode = OP_R; ack = 1'b1;
        #1 chk("r_idle", 8'(state), 8'(ST_IDLE));
        tick; chk("r_fetch", 8'(state), 8'(ST_FETCH));
        chk("r_fetch_req", 8'(mem_req), 8'd1);
        chk("r_fetch_we", 8'(mem_we), 8'd0);
        chk("r_fetch_irwe", 8'(ir_we), 8'd1);
        chk("r_fetch_busy", 8'(busy), 8'd1);
        tick; chk("r_decode", 8'(state), 8'(ST_DECODE));
        tick; chk("r_exec", 8'(state), 8'(ST_EXECUTE));
        chk("r_exec_alusrc", 8'(alusrc), 8'd0);
        chk("r_exec_pcwe", 8'(pc_we), 8'd0);
        tick; chk("r_wb", 8'(state), 8'(ST_WB));
        chk("r_wb_regwrite", 8'(regwrite), 8'd1);
        chk("r_wb_wbsel", 8'(wbsel), 8'd0);
        chk("r_wb_pcwe", 8'(pc_we), 8'd1);
        chk("r_wb_pcsrc", 8'(pc_src), 8'd0);

        // LOAD with data ack delayed 3 cycles
        opcode = OP_LOAD;
        tick; chk("ld_fetch", 8'(state), 8'(ST_FETCH));
        tick; chk("ld_decode", 8'(state), 8'(ST_DECODE));
        tick; chk("ld_exec_alusrc", 8'(alusrc), 8'd1);
        ack = 1'b0;
        tick;
        for (int i = 0; i < 4; i++) begin
            ack = (i == 3);
            #1;
            chk("ld_mem_state", 8'(state), 8'(ST_MEM));
            chk("ld_mem_req", 8'(mem_req), 8'd1);
            chk("ld_mem_we", 8'(mem_we), 8'd0);
            chk("ld_mem_pcwe", 8'(pc_we), 8'd0);
            tick;
        end
        chk("ld_wb", 8'(state), 8'(ST_WB));
        chk("ld_wb_wbsel", 8'(wbsel), 8'd1);
        chk("ld_wb_regwrite", 8'(regwrite), 8'd1);
        run = 1'b0;
        tick; chk("ld_idle", 8'(state), 8'(ST_IDLE));
        chk("ld_idle_busy", 8'(busy), 8'd0);

        // BRANCH taken then not taken
        run = 1'b1; opcode = OP_BRANCH; ack = 1'b1; taken = 1'b1;
        tick; tick; tick;
        chk("br_exec", 8'(state), 8'(ST_EXECUTE));
        chk("br_pcwe", 8'(pc_we), 8'd1);
        chk("br_pcsrc", 8'(pc_src), 8'd1);
        chk("br_regwrite", 8'(regwrite), 8'd0);
        taken = 1'b0;
        tick; chk("br_next_fetch", 8'(state), 8'(ST_FETCH));
        tick; tick;
        chk("brn_pcwe", 8'(pc_we), 8'd1);
        chk("brn_pcsrc", 8'(pc_src), 8'd0);
        run = 1'b0;
        tick; chk("br_idle", 8'(state), 8'(ST_IDLE));

        // I-ALU then JAL back to back
        run = 1'b1; opcode = OP_IALU;
        tick; tick; tick;
        chk("ia_alusrc", 8'(alusrc), 8'd1);
        tick; chk("ia_wbsel", 8'(wbsel), 8'd0);
        chk("ia_pcsrc", 8'(pc_src), 8'd0);
        opcode = OP_JAL;
        tick; tick; tick;
        chk("jal_alusrc", 8'(alusrc), 8'd0);
        tick; chk("jal_wb", 8'(state), 8'(ST_WB));
        chk("jal_wbsel", 8'(wbsel), 8'd2);
        chk("jal_pcsrc", 8'(pc_src), 8'd1);
        run = 1'b0;
        tick; chk("jal_idle", 8'(state), 8'(ST_IDLE));

        // STORE completing in MEM
        run = 1'b1; opcode = OP_STORE;
        tick; tick; tick;
        chk("st_alusrc", 8'(alusrc), 8'd1);
        tick; chk("st_mem", 8'(state), 8'(ST_MEM));
        chk("st_mem_we", 8'(mem_we), 8'd1);
        chk("st_pcwe", 8'(pc_we), 8'd1);
        chk("st_pcsrc", 8'(pc_src), 8'd0);
        run = 1'b0;
        tick; chk("st_idle", 8'(state), 8'(ST_IDLE));

        // Async reset during STORE MEM
        run = 1'b1;
        tick; tick; ack = 1'b0;
        tick; tick;
        chk("strst_req_before", 8'(mem_req), 8'd1);
        chk("strst_we_before", 8'(mem_we), 8'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("strst_req", 8'(mem_req), 8'd0);
        chk("strst_state", 8'(state), 8'(ST_IDLE));
        run = 1'b0;
        #2 rst_n = 1'b1;
        tick; chk("strst_idle", 8'(state), 8'(ST_IDLE));

        // Ack arriving in the 16th FETCH cycle beats the timeout
        run = 1'b1; opcode = OP_R; ack = 1'b0;
        tick;
        for (int c = 2; c <= 16; c++) tick;
        chk("to16_state", 8'(state), 8'(ST_FETCH));
        ack = 1'b1;
        #1 chk("to16_irwe", 8'(ir_we), 8'd1);
        run = 1'b0;
        tick; chk("to16_decode", 8'(state), 8'(ST_DECODE));
        chk("to16_err", 8'(err), 8'd0);
        tick; tick; tick;
        chk("to16_idle", 8'(state), 8'(ST_IDLE));
        chk("to16_err_end", 8'(err), 8'd0);

        // Timeout fires after 16 ack-less FETCH cycles
        run = 1'b1; ack = 1'b0;
        tick;
        for (int c = 2; c <= 16; c++) tick;
        chk("to_c16_state", 8'(state), 8'(ST_FETCH));
        chk("to_c16_err", 8'(err), 8'd0);
        tick; chk("to_state", 8'(state), 8'(ST_IDLE));
        chk("to_err", 8'(err), 8'd1);
        chk("to_busy", 8'(busy), 8'd0);
        tick; chk("to_ignore_run", 8'(state), 8'(ST_IDLE));
        chk("to_err_sticky", 8'(err), 8'd1);
        chk("to_req", 8'(mem_req), 8'd0);
        rst_n = 1'b0;
        #1 chk("to_err_rst", 8'(err), 8'd0);
        #2 rst_n = 1'b1;

        // Unrecognised opcode
        run = 1'b1; ack = 1'b1; opcode = 7'h7F;
        tick; tick;
        chk("ill_decode", 8'(state), 8'(ST_DECODE));
`ifdef CTRL_ILLEGAL_TRAP_EN
        chk("ill_pcwe", 8'(pc_we), 8'd0);
        tick; chk("ill_trap", 8'(state), 8'(ST_TRAP));
        chk("ill_err", 8'(err), 8'd1);
        tick; chk("ill_trap_hold", 8'(state), 8'(ST_TRAP));
`else
        chk("nop_pcwe", 8'(pc_we), 8'd1);
        chk("nop_pcsrc", 8'(pc_src), 8'd0);
        run = 1'b0;
        tick; chk("nop_idle", 8'(state), 8'(ST_IDLE));
        chk("nop_err", 8'(err), 8'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
